alu_sequencer: RTL and testbench

- Command-side master for the 8-bit registered ALU: accepts one operation per handshake (opcode, two operands), drives the ALU's op/in1/in2 inputs, and waits out the ALU's one-clock registered latency.
- Captures the ALU result and returns it on a valid/ready response port.
- Rejects illegal opcodes locally and never issues them to the ALU.
- Keeps completed-op and error counters for debug.

---
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-side master for the 8-bit registered ALU.
// Accepts one op per handshake, drives the ALU for a single ISSUE cycle,
// captures the result one clock later and returns it on a valid/ready port.
// Illegal opcodes are answered locally with rsp_err and never reach the ALU.
module alu_sequencer #(
  parameter int          DATA_W = 8,
  parameter int          CNT_W  = 16,
  parameter logic [7:0]  NOP_OP = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [7:0]        alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  done_count,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t              r_state,     w_state_nxt;
  logic                r_cmd_ready, w_cmd_ready_nxt;
  logic [7:0]          r_alu_op,    w_alu_op_nxt;
  logic [DATA_W-1:0]   r_alu_in1,   w_alu_in1_nxt;
  logic [DATA_W-1:0]   r_alu_in2,   w_alu_in2_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_data,  w_rsp_data_nxt;
  logic                r_rsp_err,   w_rsp_err_nxt;
  logic [CNT_W-1:0]    r_done_cnt,  w_done_cnt_nxt;
  logic [7:0]          r_err_cnt,   w_err_cnt_nxt;
  logic                w_legal;

  // Opcode legality decode; NOP_OP is deliberately not in the list.
  always_comb begin
    w_legal = 1'b0;
    case (cmd_op)
      8'h01, 8'h02, 8'h0E, 8'h0F, 8'h10, 8'h11, 8'h13, 8'h14: w_legal = 1'b1;
      default:                                                w_legal = 1'b0;
    endcase
  end

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    w_state_nxt     = r_state;
    w_alu_op_nxt    = r_alu_op;
    w_alu_in1_nxt   = r_alu_in1;
    w_alu_in2_nxt   = r_alu_in2;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_err_nxt   = r_rsp_err;
    w_done_cnt_nxt  = r_done_cnt;
    w_err_cnt_nxt   = r_err_cnt;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (w_legal) begin
            w_alu_op_nxt  = cmd_op;
            w_alu_in1_nxt = cmd_a;
            w_alu_in2_nxt = cmd_b;
            w_state_nxt   = S_ISSUE;
          end else begin
            // answered on the accepting edge; ALU inputs untouched
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_data_nxt  = '0;
            w_state_nxt     = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        // ALU samples the op on this edge; park it on NOP so it holds the result
        w_alu_op_nxt = NOP_OP;
        w_state_nxt  = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_rsp_data_nxt  = alu_result;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_valid_nxt = 1'b1;
        w_state_nxt     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          if (r_rsp_err) begin
            if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
          end else begin
            w_done_cnt_nxt = r_done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // registered ready: high exactly while the FSM sits in IDLE
    w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State and output registers; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_alu_op    <= NOP_OP;
      r_alu_in1   <= '0;
      r_alu_in2   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_done_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_alu_op    <= w_alu_op_nxt;
      r_alu_in1   <= w_alu_in1_nxt;
      r_alu_in2   <= w_alu_in2_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_done_cnt  <= w_done_cnt_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign alu_op     = r_alu_op;
  assign alu_in1    = r_alu_in1;
  assign alu_in2    = r_alu_in2;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign done_count = r_done_cnt;
  assign err_count  = r_err_cnt;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural registered ALU attached.
// A second instance with CNT_W=4 shares the stimulus to exercise counter wrap.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_op = 8'h00, cmd_a = 8'h00, cmd_b = 8'h00;
  logic [7:0] alu_op, alu_in1, alu_in2;
  logic [7:0] alu_res = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [15:0] done_count;
  logic [7:0] err_count;

  logic       c4_ready, c4_valid, c4_err;
  logic [7:0] c4_op, c4_in1, c4_in2, c4_data, c4_errcnt;
  logic [3:0] c4_done;

  int n_chk = 0;
  int n_fail = 0;
  int exp_done = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(8), .CNT_W(16), .NOP_OP(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .done_count(done_count), .err_count(err_count));

  // Narrow-counter copy; it sees identical stimulus so the shared ALU result fits.
  alu_sequencer #(.DATA_W(8), .CNT_W(4), .NOP_OP(8'h00)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(c4_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(c4_op), .alu_in1(c4_in1), .alu_in2(c4_in2), .alu_result(alu_res),
    .rsp_valid(c4_valid), .rsp_ready(rsp_ready), .rsp_data(c4_data),
    .rsp_err(c4_err), .done_count(c4_done), .err_count(c4_errcnt));

  // Registered ALU: one-clock latency, holds its result on NOP/unknown ops.
  always @(posedge clk) begin
    case (alu_op)
      8'h01: alu_res <= alu_in1 + alu_in2;
      8'h02: alu_res <= alu_in1 - alu_in2;
      8'h0E: alu_res <= ~alu_in1;
      8'h0F: alu_res <= alu_in1 & alu_in2;
      8'h10: alu_res <= alu_in1 | alu_in2;
      8'h11: alu_res <= alu_in1 ^ alu_in2;
      8'h13: alu_res <= alu_in1 >> 1;
      8'h14: alu_res <= alu_in1 << 1;
      default: alu_res <= alu_res;
    endcase
  end

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       err;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one command and follow it until rsp_valid, checking latency and data.
  task automatic issue(input vec_t v);
    int t;
    int lat;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("ready_after_accept", cmd_ready, 0);
    if (!v.err) begin
      chk("alu_op_issue", alu_op, v.op);
      chk("alu_in1_issue", alu_in1, v.a);
      chk("alu_in2_issue", alu_in2, v.b);
    end else begin
      chk("alu_op_illegal", alu_op, 0);
    end
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
      chk("alu_op_nop", alu_op, 0);
      chk("ready_busy", cmd_ready, 0);
    end
    // legal ops land two edges after acceptance; illegal ones on the accepting edge
    chk("latency", lat, v.err ? 0 : 2);
    chk("rsp_data", rsp_data, v.d);
    chk("rsp_err", rsp_err, v.err);
  endtask

  // Complete the handshake (rsp_ready already high) and check the counters.
  task automatic handshake(input logic was_err);
    @(posedge clk); #1;
    if (was_err) begin
      if (exp_err != 255) exp_err++;
    end else begin
      exp_done++;
    end
    chk("valid_cleared", rsp_valid, 0);
    chk("ready_idle", cmd_ready, 1);
    chk("done_count", done_count, exp_done);
    chk("err_count", err_count, exp_err);
    chk("done4", c4_done, exp_done % 16);
  endtask

  initial begin
    vt[0] = '{8'h01, 8'hF0, 8'h20, 8'h10, 1'b0};  // ADD wraps
    vt[1] = '{8'h02, 8'h05, 8'h07, 8'hFE, 1'b0};  // SUB
    vt[2] = '{8'h11, 8'hAA, 8'h0F, 8'hA5, 1'b0};  // XOR
    vt[3] = '{8'h13, 8'h81, 8'h00, 8'h40, 1'b0};  // RSHIFT
    vt[4] = '{8'h14, 8'h81, 8'h00, 8'h02, 1'b0};  // LSHIFT
    vt[5] = '{8'h0E, 8'h5A, 8'h00, 8'hA5, 1'b0};  // CPL
    vt[6] = '{8'h10, 8'h0C, 8'h30, 8'h3C, 1'b0};  // OR
    vt[7] = '{8'h03, 8'h11, 8'h22, 8'h00, 1'b1};  // illegal
    vt[8] = '{8'h00, 8'h33, 8'h44, 8'h00, 1'b1};  // NOP is illegal
    vt[9] = '{8'hFF, 8'h55, 8'h66, 8'h00, 1'b1};  // illegal

    // reset state
    #12;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_done", done_count, 0);
    chk("rst_err", err_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", cmd_ready, 1);

    // table-driven vectors, rsp_ready tied high
    for (int i = 0; i < 10; i++) begin
      issue(vt[i]);
      handshake(vt[i].err);
    end
    chk("done_after_table", done_count, 7);
    chk("err_after_table", err_count, 3);

    // backpressure on AND 3C&F0, with a competing command waiting
    rsp_ready = 1'b0;
    issue('{8'h0F, 8'h3C, 8'hF0, 8'h30, 1'b0});
    cmd_valid = 1'b1; cmd_op = 8'h01; cmd_a = 8'h01; cmd_b = 8'h01;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 8'h30);
      chk("bp_ready", cmd_ready, 0);
      chk("bp_alu_op", alu_op, 0);
    end
    chk("bp_done_hold", done_count, exp_done);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    handshake(1'b0);
    @(posedge clk); #1;
    chk("bp_no_extra", rsp_valid, 0);
    chk("bp_no_issue", alu_op, 0);
    chk("bp_data_hold", rsp_data, 8'h30);

    // reset in the middle of CAPTURE
    cmd_valid = 1'b1; cmd_op = 8'h01; cmd_a = 8'h10; cmd_b = 8'h20;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_alu_op", alu_op, 0);
    chk("mid_rst_done", done_count, 0);
    chk("mid_rst_err", err_count, 0);
    exp_done = 0; exp_err = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_mid_rst", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("no_stale_rsp", rsp_valid, 0);
    end

    // err_count saturation
    for (int i = 0; i < 256; i++) begin
      issue(vt[7 + (i % 3)]);
      handshake(1'b1);
    end
    chk("err_sat", err_count, 255);
    issue(vt[7]);
    handshake(1'b1);
    chk("err_sat_hold", err_count, 255);

    // done_count wrap on the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      issue(vt[i % 7]);
      handshake(1'b0);
    end
    chk("done16", done_count, 16);
    chk("done4_wrap", c4_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Safety net against a hung FSM.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
